// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the RV32 core.
// Carries a valid bit, a control bundle and a data payload through a chain of
// DEPTH register stages, with stall (hold), flush (masked bubble) and
// synchronous active-high reset.
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/flush counters
// (stall_cnt_o, flush_cnt_o). Without it those ports and their logic are absent.
module pipe_stage_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CTRL_WIDTH = 16,
    parameter logic [CTRL_WIDTH-1:0] KILL_MASK  = 16'h00FF,
    parameter int                    DEPTH      = 1,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [DATA_WIDTH-1:0] data_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
`endif
);

    // Configuration guard: the chain only supports 1..4 stages.
    generate
        if (DEPTH < 1 || DEPTH > 4 || CNT_WIDTH < 1) begin : g_cfg_err
            $error("pipe_stage_reg: DEPTH must be within 1..4 and CNT_WIDTH >= 1");
        end
    endgenerate

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [CTRL_WIDTH-1:0] ctrl_q [DEPTH];
    logic [CTRL_WIDTH-1:0] ctrl_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    // Next-state for the chain: flush kills in place, advance shifts, stall holds.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < DEPTH; k++) begin
            ctrl_d[k] = ctrl_q[k];
            data_d[k] = data_q[k];
        end
        if (flush_i) begin
            // Payload and unmasked control bits stay put so the datapath does not toggle.
            for (int k = 0; k < DEPTH; k++) begin
                valid_d[k] = 1'b0;
                ctrl_d[k]  = ctrl_q[k] & ~KILL_MASK;
            end
        end else if (en_i) begin
            valid_d[0] = valid_i;
            // A bubble entering the chain never carries a killable control bit.
            ctrl_d[0]  = valid_i ? ctrl_i : (ctrl_i & ~KILL_MASK);
            data_d[0]  = data_i;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers with synchronous reset that overrides flush and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= ctrl_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign ctrl_o  = ctrl_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Counter next-state: count stall-only and flush cycles, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_i) begin
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else if (!en_i) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 1, 2, 3) share stimulus.
// Each stimulus cycle pushes a hand-computed expectation tagged with the
// instance to check; a monitor pops one entry per cycle and compares.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst, en, flush, vin;
    logic [15:0] ci;
    logic [31:0] di;

    logic        v1, v2, v3;
    logic [15:0] c1, c2, c3;
    logic [31:0] d1, d2, d3;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]  sc1, fc1, sc2, fc2, sc3, fc3;
`endif

    pipe_stage_reg #(.DEPTH(1)
`ifdef PIPE_PERF_CNT_EN
        , .CNT_WIDTH(4)
`endif
    ) u1 (
        .clk(clk), .rst(rst), .en_i(en), .flush_i(flush), .valid_i(vin),
        .ctrl_i(ci), .data_i(di), .valid_o(v1), .ctrl_o(c1), .data_o(d1)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt_o(sc1), .flush_cnt_o(fc1)
`endif
    );

    pipe_stage_reg #(.DEPTH(2)
`ifdef PIPE_PERF_CNT_EN
        , .CNT_WIDTH(4)
`endif
    ) u2 (
        .clk(clk), .rst(rst), .en_i(en), .flush_i(flush), .valid_i(vin),
        .ctrl_i(ci), .data_i(di), .valid_o(v2), .ctrl_o(c2), .data_o(d2)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt_o(sc2), .flush_cnt_o(fc2)
`endif
    );

    pipe_stage_reg #(.DEPTH(3)
`ifdef PIPE_PERF_CNT_EN
        , .CNT_WIDTH(4)
`endif
    ) u3 (
        .clk(clk), .rst(rst), .en_i(en), .flush_i(flush), .valid_i(vin),
        .ctrl_i(ci), .data_i(di), .valid_o(v3), .ctrl_o(c3), .data_o(d3)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt_o(sc3), .flush_cnt_o(fc3)
`endif
    );

    typedef struct {
        int          sel;   // 0 none, 1..3 instance, 4 counters of u1
        logic        v;
        logic [15:0] c;     // ctrl, or flush count for sel 4
        logic [31:0] d;     // data, or stall count for sel 4
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_checks;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge and queue its expectation.
    task automatic step(input logic r, input logic e, input logic f, input logic v,
                        input logic [15:0] c, input logic [31:0] d, input int sel,
                        input logic ev, input logic [15:0] ec, input logic [31:0] ed,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; flush = f; vin = v; ci = c; di = d;
        x.sel = sel; x.v = ev; x.c = ec; x.d = ed; x.nm = nm;
        q.push_back(x);
    endtask

    // Monitor: after every rising edge take the next expectation and compare.
    initial begin
        exp_t        x;
        logic        av;
        logic [15:0] ac;
        logic [31:0] ad;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.sel >= 1 && x.sel <= 3) begin
                    case (x.sel)
                        1:       begin av = v1; ac = c1; ad = d1; end
                        2:       begin av = v2; ac = c2; ad = d2; end
                        default: begin av = v3; ac = c3; ad = d3; end
                    endcase
                    n_checks++;
                    if ({av, ac, ad} !== {x.v, x.c, x.d}) begin
                        n_fail++;
                        $display("FAIL %s: got valid=%0b ctrl=%h data=%h, expected valid=%0b ctrl=%h data=%h",
                                 x.nm, av, ac, ad, x.v, x.c, x.d);
                    end
                end
`ifdef PIPE_PERF_CNT_EN
                else if (x.sel == 4) begin
                    n_checks++;
                    if (sc1 !== x.d[3:0] || fc1 !== x.c[3:0]) begin
                        n_fail++;
                        $display("FAIL %s: got stall_cnt=%h flush_cnt=%h, expected stall_cnt=%h flush_cnt=%h",
                                 x.nm, sc1, fc1, x.d[3:0], x.c[3:0]);
                    end
                end
`endif
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; en = 1'b0; flush = 1'b0; vin = 1'b0; ci = 16'h0000; di = 32'h0;

        // Reset (with a valid input present), DEPTH=1 pass-through, bubble, stall
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 32'hDEADBEEF, 1, 1'b0, 16'h0000, 32'h0, "t1_rst_a");
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 32'hDEADBEEF, 3, 1'b0, 16'h0000, 32'h0, "t1_rst_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 32'hDEADBEEF, 1, 1'b1, 16'h1234, 32'hDEADBEEF, "t1_pass");
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h00000055, 1, 1'b0, 16'hFF00, 32'h00000055, "t4_bubble");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 32'h00007777, 1, 1'b0, 16'hFF00, 32'h00000055, "t1_stall_hold");

        // DEPTH=3 streaming with a two-cycle stall
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 3, 1'b0, 16'h0000, 32'd0, "t2_rst_a");
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 2, 1'b0, 16'h0000, 32'd0, "t2_rst_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 32'd1, 3, 1'b0, 16'h0000, 32'd0, "t2_lat_a");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 32'd2, 3, 1'b0, 16'h0000, 32'd0, "t2_lat_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 32'd3, 3, 1'b1, 16'h0001, 32'd1, "t2_out1");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 32'd4, 3, 1'b1, 16'h0002, 32'd2, "t2_out2");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0063, 32'd99, 3, 1'b1, 16'h0002, 32'd2, "t2_stall_a");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0063, 32'd99, 3, 1'b1, 16'h0002, 32'd2, "t2_stall_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 32'd5, 3, 1'b1, 16'h0003, 32'd3, "t2_resume3");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0006, 32'd6, 3, 1'b1, 16'h0004, 32'd4, "t2_out4");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0007, 32'd7, 3, 1'b1, 16'h0005, 32'd5, "t2_out5");

        // DEPTH=2 flush during stall, refill, back-to-back flushes, bubble entry
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 2, 1'b0, 16'h0000, 32'd0, "t3_rst_a");
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 2, 1'b0, 16'h0000, 32'd0, "t3_rst_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 32'd10, 2, 1'b0, 16'h0000, 32'd0, "t3_fill");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 32'd11, 2, 1'b1, 16'hFFFF, 32'd10, "t3_full");
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 32'd99, 2, 1'b0, 16'hFF00, 32'd10, "t3_flush");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 32'd98, 2, 1'b0, 16'hFF00, 32'd10, "t3_flush_hold");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h00AA, 32'd12, 2, 1'b0, 16'hFF00, 32'd11, "t3_s0_killed");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0055, 32'd13, 2, 1'b1, 16'h00AA, 32'd12, "t3_refill");
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'd14, 2, 1'b0, 16'h0000, 32'd12, "t3_flush2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'd15, 2, 1'b0, 16'h0000, 32'd12, "t3_flush3");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0101, 32'd16, 2, 1'b0, 16'h0000, 32'd13, "t3_after_a");
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 32'd17, 2, 1'b1, 16'h0101, 32'd16, "t3_after_b");
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'd18, 2, 1'b0, 16'hFF00, 32'd17, "t3_bubble_d2");

        // DEPTH=3 reset mid-stream together with flush and enable
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 32'd20, 0, 1'b0, 16'h0000, 32'd0, "t5_fill_a");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 32'd21, 0, 1'b0, 16'h0000, 32'd0, "t5_fill_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 32'd22, 3, 1'b1, 16'h0F0F, 32'd20, "t5_stream");
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 32'd23, 3, 1'b0, 16'h0000, 32'd0, "t5_rst_flush");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 32'd30, 3, 1'b0, 16'h0000, 32'd0, "t5_lat_a");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 32'd31, 3, 1'b0, 16'h0000, 32'd0, "t5_lat_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 32'd32, 3, 1'b1, 16'h0F0F, 32'd30, "t5_first");

`ifdef PIPE_PERF_CNT_EN
        // Counters (4-bit): saturation of stall count, flush/stall overlap
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 4, 1'b0, 16'h0000, 32'd0, "t6_rst");
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 4, 1'b0, 16'h0000,
                 (i > 15) ? 32'd15 : 32'(i), "t6_stall");
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 4, 1'b0, 16'h0000, 32'd0, "t6_clr");
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 32'd0, 4, 1'b0, 16'h0001, 32'd0, "t6_flush_stall");
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'd0, 4, 1'b0, 16'h0002, 32'd0, "t6_flush_b");
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'd0, 4, 1'b0, 16'h0003, 32'd0, "t6_flush_c");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 4, 1'b0, 16'h0003, 32'd1, "t6_stall_after");
`endif

        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'd0, 0, 1'b0, 16'h0000, 32'd0, "drain");
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
